parking_sensor_gen: RTL and testbench
=====================================

// Module: parking_sensor_gen
// PURPOSE
//  Car-passage stimulus generator: the driving end of the two-sensor parking-lot interface.
//  Queued "car enters" / "car exits" requests become timed sensor_a/sensor_b waveforms.
//  Waveforms are active-low, with the same shape the in/out FSM decodes.
//  Used for hardware self-test: outputs feed the lot's sensor inputs through its debouncers.
// PARAMETERS
//  STEP_CYCLES  480000  clocks each sensor phase is held (must exceed debouncer count; >=1)
//  GAP_CYCLES   480000  clocks both sensors stay clear after a car before the next one (>=1)
//  QUEUE_DEPTH  4       pending-request FIFO depth (power of two, >=2)
// PORTS
//  clk        in   1  system clock
//  reset      in   1  asynchronous, active-high reset
//  req_in     in   1  1-cycle pulse: enqueue one entering car
//  req_out    in   1  1-cycle pulse: enqueue one exiting car
//  sensor_a   out  1  emulated sensor A, active-low (1 = beam clear)
//  sensor_b   out  1  emulated sensor B, active-low
//  busy       out  1  high from pop through final gap cycle of current car
//  dir        out  1  direction of current car: 1 = entry, 0 = exit; holds last value when idle
//  done       out  1  1-cycle pulse in last gap cycle of a completed car
//  drop       out  1  1-cycle pulse when a request is discarded (queue full)
//  q_count    out  $clog2(QUEUE_DEPTH)+1  pending requests in FIFO
// BEHAVIOUR
//  Reset (async, any time incl. mid-car): sensor_a=sensor_b=1, busy=0, dir=0, done=0, drop=0.
//  Reset also clears q_count=0 and returns FSM to IDLE.
//  FIFO: 1-bit entries (1=entry, 0=exit), written at clock edge when a request is sampled.
//  req_in and req_out in the same cycle: req_in written first, then req_out.
//  Full check uses occupancy after this cycle's pop; a request with no free slot is discarded.
//  If only one slot is free on simultaneous requests, req_out is discarded.
//  drop pulses once per cycle with >=1 discard.
//  FSM (active-high view ab = {~sensor_a,~sensor_b}; all outputs registered):
//   IDLE: ab=00, busy=0. FIFO non-empty -> pop, load dir, go P1.
//   P1: entry ab=10 / exit ab=01, STEP_CYCLES cycles -> P2.
//   P2: ab=11, STEP_CYCLES cycles -> P3.
//   P3: entry ab=01 / exit ab=10, STEP_CYCLES cycles -> GAP.
//   GAP: ab=00, GAP_CYCLES cycles; done=1 in last cycle; then IDLE.
//  Latency: request sampled at edge k into empty queue, FSM idle -> pop at edge k+1.
//  P1 values are visible after edge k+1.
//  Back-to-back: next pop on the edge leaving GAP, with no extra IDLE cycle.
//  Per car, busy is high for 3*STEP_CYCLES+GAP_CYCLES cycles.
//  Phase counter: $clog2(max(STEP,GAP)+1) bits; reloads on every state change; never wraps.
//  sensor_a and sensor_b never change in the same cycle (Gray-coded phases).
// CONFIGURATION
//  PARK_ABORT_EN defined:
//   - Adds input port `abort` (1 bit, level-sampled), placed after req_out.
//   - abort=1 in P1/P2/P3 makes the car back out: current phase restarts its count.
//   - Phases then run in reverse order (P3->P2->P1->GAP), STEP_CYCLES each.
//   - Waveform retraces to ab=00; the decoder must count nothing.
//   - done stays 0 for an aborted car; a 1-cycle `aborted` output pulses in its last GAP cycle.
//   - abort in IDLE or GAP, or while already reversing: ignored.
//  PARK_ABORT_EN undefined: no abort/aborted ports and no reverse path; behaviour as above.
// TESTING  (STEP_CYCLES=4, GAP_CYCLES=2, QUEUE_DEPTH=4)
//  1. Entry: req_in pulse at edge 0.
//     -> edges1-4 ab=10, 5-8 ab=11, 9-12 ab=01, 13-14 ab=00.
//     -> done=1 only in cycle 14, busy=1 for cycles 1-14, dir=1.
//  2. Exit: req_out pulse -> ab sequence 01,11,10,00 with the same timing, dir=0, one done.
//  3. Simultaneous + back-to-back: req_in&req_out same cycle, idle -> entry car then exit car.
//     -> second P1 starts on the edge after the first done; 2 done pulses total; drop=0.
//  4. Overflow: 6 req_in pulses on consecutive cycles while idle.
//     -> 1 popped, 4 queued, 1 dropped: drop=1 on 6th.
//     -> q_count peaks at 4; exactly 5 cars generated.
//  5. Reset mid-P2 of an entry with 2 queued.
//     -> same cycle: sensor_a=sensor_b=1, busy=0, q_count=0; no done; no cars afterwards.
//  6. (PARK_ABORT_EN) Entry, abort=1 for 1 cycle at 2nd P2 cycle.
//     -> ab 10x4, 11x(2+4), 10x4, 00x2; aborted=1 once; done never pulses.

Source files
------------

// File: rtl/parking_sensor_gen.sv
// parking_sensor_gen: queued entry/exit requests become timed active-low two-sensor car waveforms.
// Optional PARK_ABORT_EN adds an abort input that makes the current car back out.
module parking_sensor_gen #(
  parameter int STEP_CYCLES = 480000,
  parameter int GAP_CYCLES = 480000,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req_in,
  input  logic req_out,
`ifdef PARK_ABORT_EN
  input  logic abort,
  output logic aborted,
`endif
  output logic sensor_a,
  output logic sensor_b,
  output logic busy,
  output logic dir,
  output logic done,
  output logic drop,
  output logic [$clog2(QUEUE_DEPTH):0] q_count
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int MAXC = STEP_CYCLES > GAP_CYCLES ? STEP_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] STEP_L = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] GAP_L = CW'(GAP_CYCLES - 1);
  localparam logic [AW:0] QD = (AW+1)'(QUEUE_DEPTH);
  typedef enum logic [2:0] {IDLE, P1, P2, P3, GAP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QUEUE_DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] fill_q, fill_d, fill_a;
  logic dir_q, dir_d, busy_q, busy_d, done_q, done_d, drop_q, drop_d;
  logic sensor_a_q, sensor_b_q;
  logic [1:0] ab_d;
  logic last, pop, wi, wo, restart, fin;
`ifdef PARK_ABORT_EN
  logic rev_q, rev_d, aborted_q, aborted_d;
`else
  localparam logic rev_q = 1'b0;
  localparam logic rev_d = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mem_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      fill_q <= '0;
      dir_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      drop_q <= 1'b0;
      sensor_a_q <= 1'b1;
      sensor_b_q <= 1'b1;
`ifdef PARK_ABORT_EN
      rev_q <= 1'b0;
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      fill_q <= fill_d;
      dir_q <= dir_d;
      busy_q <= busy_d;
      done_q <= done_d;
      drop_q <= drop_d;
      sensor_a_q <= ~ab_d[1];
      sensor_b_q <= ~ab_d[0];
`ifdef PARK_ABORT_EN
      rev_q <= rev_d;
      aborted_q <= aborted_d;
`endif
    end
  end
  // Free-slot check sees this cycle's pop; req_in claims a slot before req_out.
  always_comb begin
    last = cnt_q == '0;
    pop = (state_q == IDLE || (state_q == GAP && last)) && fill_q != '0;
    fill_a = fill_q - (AW+1)'(pop);
    wi = req_in && fill_a < QD;
    wo = req_out && fill_a + (AW+1)'(wi) < QD;
    fill_d = fill_a + (AW+1)'(wi) + (AW+1)'(wo);
    rd_d = rd_q + AW'(pop);
    wr_d = wr_q + AW'(wi) + AW'(wo);
    mem_d = mem_q;
    if (wi) mem_d[wr_q] = 1'b1;
    if (wo) mem_d[wr_q + AW'(wi)] = 1'b0;
    restart = 1'b0;
`ifdef PARK_ABORT_EN
    restart = abort && !rev_q && (state_q == P1 || state_q == P2 || state_q == P3);
    rev_d = pop ? 1'b0 : rev_q | restart;
`endif
    case (state_q)
      IDLE:    state_d = pop ? P1 : IDLE;
      P1:      state_d = last ? (rev_q ? GAP : P2) : P1;
      P2:      state_d = last ? (rev_q ? P1 : P3) : P2;
      P3:      state_d = last ? (rev_q ? P2 : GAP) : P3;
      GAP:     state_d = last ? (pop ? P1 : IDLE) : GAP;
      default: state_d = IDLE;
    endcase
    if (restart) state_d = state_q;
    cnt_d = (state_d != state_q || restart) ?
            (state_d == GAP ? GAP_L : state_d == IDLE ? '0 : STEP_L) :
            (last ? cnt_q : cnt_q - 1'b1);
  end
  always_comb begin
    dir_d = pop ? mem_q[rd_q] : dir_q;
    busy_d = state_d != IDLE;
    ab_d = state_d == P2 ? 2'b11 : state_d == P1 ? {dir_d, !dir_d} :
           state_d == P3 ? {!dir_d, dir_d} : 2'b00;
    fin = state_d == GAP && cnt_d == '0;
    done_d = fin && !rev_d;
    drop_d = (req_in && !wi) || (req_out && !wo);
`ifdef PARK_ABORT_EN
    aborted_d = fin && rev_d;
`endif
  end
  assign sensor_a = sensor_a_q;
  assign sensor_b = sensor_b_q;
  assign busy = busy_q;
  assign dir = dir_q;
  assign done = done_q;
  assign drop = drop_q;
  assign q_count = fill_q;
`ifdef PARK_ABORT_EN
  assign aborted = aborted_q;
`endif
endmodule

// File: tb/tb_parking_sensor_gen.sv
// tb_parking_sensor_gen: directed checks of car waveforms, queueing, overflow and reset.
module tb_parking_sensor_gen;
  logic clk = 1'b0, reset = 1'b1, req_in = 1'b0, req_out = 1'b0;
  logic sensor_a, sensor_b, busy, dir, done, drop;
  logic [2:0] q_count;
  int checks = 0, fails = 0;
`ifdef PARK_ABORT_EN
  logic abort = 1'b0, aborted;
`endif
  wire [1:0] ab = {~sensor_a, ~sensor_b};
  always #5 clk = ~clk;
  parking_sensor_gen #(.STEP_CYCLES(4), .GAP_CYCLES(2), .QUEUE_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .req_in(req_in), .req_out(req_out),
`ifdef PARK_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .sensor_a(sensor_a), .sensor_b(sensor_b), .busy(busy), .dir(dir),
    .done(done), .drop(drop), .q_count(q_count)
  );
  function automatic logic [1:0] exp_ab(int i, logic d);
    if (i >= 1 && i <= 4) return d ? 2'b10 : 2'b01;
    if (i >= 5 && i <= 8) return 2'b11;
    if (i >= 9 && i <= 12) return d ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sensor_a, sensor_b, busy, dir, done, drop} !== 6'b110000) begin
      fails++;
      $display("FAIL reset outputs: got %b expected 110000", {sensor_a, sensor_b, busy, dir, done, drop});
    end
    checks++;
    if (q_count !== 3'd0) begin
      fails++;
      $display("FAIL reset q_count: got %0d expected 0", q_count);
    end
    reset = 1'b0;
  endtask
  task automatic test_entry();
    @(negedge clk) req_in = 1'b1;
    @(posedge clk);
    @(negedge clk) req_in = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (ab !== exp_ab(i, 1'b1)) begin
        fails++;
        $display("FAIL entry ab cycle %0d: got %b expected %b", i, ab, exp_ab(i, 1'b1));
      end
      checks++;
      if (busy !== (i <= 14) || done !== (i == 14) || dir !== 1'b1) begin
        fails++;
        $display("FAIL entry busy/done/dir cycle %0d: got %b%b%b expected %b%b1", i, busy, done, dir, i <= 14, i == 14);
      end
    end
  endtask
  task automatic test_exit();
    @(negedge clk) req_out = 1'b1;
    @(posedge clk);
    @(negedge clk) req_out = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (ab !== exp_ab(i, 1'b0)) begin
        fails++;
        $display("FAIL exit ab cycle %0d: got %b expected %b", i, ab, exp_ab(i, 1'b0));
      end
      checks++;
      if (busy !== (i <= 14) || done !== (i == 14) || dir !== 1'b0) begin
        fails++;
        $display("FAIL exit busy/done/dir cycle %0d: got %b%b%b expected %b%b0", i, busy, done, dir, i <= 14, i == 14);
      end
    end
  endtask
  task automatic test_back_to_back();
    int dones = 0;
    logic [1:0] e;
    @(negedge clk) begin req_in = 1'b1; req_out = 1'b1; end
    @(posedge clk);
    @(negedge clk) begin req_in = 1'b0; req_out = 1'b0; end
    for (int i = 1; i <= 29; i++) begin
      @(posedge clk);
      @(negedge clk);
      e = i <= 14 ? exp_ab(i, 1'b1) : exp_ab(i - 14, 1'b0);
      dones += int'(done);
      checks++;
      if (ab !== e) begin
        fails++;
        $display("FAIL b2b ab cycle %0d: got %b expected %b", i, ab, e);
      end
      checks++;
      if (busy !== (i <= 28) || drop !== 1'b0 || (i <= 28 && dir !== (i <= 14))) begin
        fails++;
        $display("FAIL b2b busy/drop/dir cycle %0d: got %b%b%b expected %b0%b", i, busy, drop, dir, i <= 28, i <= 14);
      end
    end
    checks++;
    if (dones != 2) begin
      fails++;
      $display("FAIL b2b done count: got %0d expected 2", dones);
    end
  endtask
  task automatic test_overflow();
    int exp_q[6] = '{1, 1, 2, 3, 4, 4};
    int dones = 0, drops = 0, peak = 0;
    @(negedge clk) req_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 5) req_in = 1'b0;
      if (int'(q_count) > peak) peak = int'(q_count);
      checks++;
      if (int'(q_count) != exp_q[i] || drop !== (i == 5)) begin
        fails++;
        $display("FAIL overflow q_count/drop edge %0d: got %0d/%b expected %0d/%b", i, q_count, drop, exp_q[i], i == 5);
      end
    end
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      dones += int'(done);
      drops += int'(drop);
      if (int'(q_count) > peak) peak = int'(q_count);
    end
    checks++;
    if (dones != 5 || drops != 0 || peak != 4) begin
      fails++;
      $display("FAIL overflow cars/drops/peak: got %0d/%0d/%0d expected 5/0/4", dones, drops, peak);
    end
    checks++;
    if (busy !== 1'b0 || q_count !== 3'd0) begin
      fails++;
      $display("FAIL overflow drained: got busy %b q_count %0d expected 0 0", busy, q_count);
    end
  endtask
  task automatic test_reset_mid();
    int dones = 0, busies = 0;
    @(negedge clk) req_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) req_in = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ab !== 2'b11 || q_count !== 3'd2) begin
      fails++;
      $display("FAIL midreset pre: got ab %b q_count %0d expected 11 2", ab, q_count);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({sensor_a, sensor_b, busy, done} !== 4'b1100 || q_count !== 3'd0) begin
      fails++;
      $display("FAIL midreset async: got %b q_count %0d expected 1100 0", {sensor_a, sensor_b, busy, done}, q_count);
    end
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      dones += int'(done);
      busies += int'(busy);
    end
    checks++;
    if (dones != 0 || busies != 0) begin
      fails++;
      $display("FAIL midreset after: got done %0d busy %0d expected 0 0", dones, busies);
    end
  endtask
`ifdef PARK_ABORT_EN
  task automatic test_abort();
    logic [1:0] e;
    @(negedge clk) req_in = 1'b1;
    @(posedge clk);
    @(negedge clk) req_in = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      @(posedge clk);
      @(negedge clk);
      e = (i >= 1 && i <= 4) || (i >= 11 && i <= 14) ? 2'b10 : (i >= 5 && i <= 10) ? 2'b11 : 2'b00;
      checks++;
      if (ab !== e) begin
        fails++;
        $display("FAIL abort ab cycle %0d: got %b expected %b", i, ab, e);
      end
      checks++;
      if (aborted !== (i == 16) || done !== 1'b0) begin
        fails++;
        $display("FAIL abort aborted/done cycle %0d: got %b%b expected %b0", i, aborted, done, i == 16);
      end
      abort = i == 6;
    end
  endtask
`endif
  initial begin
    test_reset();
    test_entry();
    test_exit();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
`ifdef PARK_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
